palm_locator: RTL

//  Front end of the finger pipeline: consumes the binary hand-mask pixel stream in raster order,

---
 rtl/palm_locator.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/palm_locator.sv
// palm_locator: scans one binary hand-mask frame in raster order, tracks the
// widest horizontal white run on eligible rows (the palm row) and publishes
// its geometry together with a frame-complete flag for the finger stage.
module palm_locator #(
    parameter int IMAGE_WIDTH    = 384,
    parameter int IMAGE_HEIGHT   = 216,
    parameter int PALM_ROW_MIN   = 90,
    parameter int MIN_PALM_WIDTH = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic       object_image,
    output logic       flag,
    output logic [8:0] palm_width,
    output logic [8:0] start_of_palm_c,
    output logic [8:0] end_of_palm_c,
    output logic [8:0] finger_width,
    output logic [8:0] palm_row
);

    localparam logic [8:0] LAST_COL = 9'(IMAGE_WIDTH - 1);
    localparam logic [8:0] LAST_ROW = 9'(IMAGE_HEIGHT - 1);
    localparam logic [8:0] ROW_MIN  = 9'(PALM_ROW_MIN);
    localparam logic [8:0] MIN_W    = 9'(MIN_PALM_WIDTH);

    // LOAD is the single cycle between the last accepted pixel and the
    // publication of results, giving the frame best one edge to settle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;

    logic [8:0] col_q, col_d;
    logic [8:0] row_q, row_d;

    logic       run_open_q, run_open_d;
    logic [8:0] run_start_q, run_start_d;

    logic [8:0] row_w_q, row_w_d;
    logic [8:0] row_s_q, row_s_d;
    logic [8:0] row_e_q, row_e_d;

    logic [8:0] best_w_q, best_w_d;
    logic [8:0] best_s_q, best_s_d;
    logic [8:0] best_e_q, best_e_d;
    logic [8:0] best_row_q, best_row_d;

    logic       flag_q, flag_d;
    logic [8:0] palm_width_q, palm_width_d;
    logic [8:0] start_q, start_d;
    logic [8:0] end_q, end_d;
    logic [8:0] finger_q, finger_d;
    logic [8:0] palm_row_q, palm_row_d;

    logic       accept;
    logic       end_of_row;
    logic       end_of_frame;

    logic       cand_valid;
    logic [8:0] cand_start;
    logic [8:0] cand_end;
    logic [8:0] cand_width;

    logic       row_upd;
    logic [8:0] row_w_new;
    logic [8:0] row_s_new;
    logic [8:0] row_e_new;
    logic       take_row;

    // A pixel only counts while scanning and when no restart wins the cycle.
    always_comb begin
        accept       = (state_q == SCAN) && pix_valid && !frame_start;
        end_of_row   = (col_q == LAST_COL);
        end_of_frame = end_of_row && (row_q == LAST_ROW);
    end

    // Next-state logic; frame_start restarts scanning from any state.
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = SCAN;
        end else begin
            case (state_q)
                SCAN:    if (accept && end_of_frame) state_d = LOAD;
                LOAD:    state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // Raster position: column advances per accepted pixel and wraps into the next row.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (frame_start) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (end_of_row) begin
                col_d = '0;
                row_d = row_q + 9'd1;
            end else begin
                col_d = col_q + 9'd1;
            end
        end
    end

    // Run tracking: produces a closed-run candidate when a black pixel ends a
    // run or when the row ends with a run still open.
    always_comb begin
        run_open_d  = run_open_q;
        run_start_d = run_start_q;
        cand_valid  = 1'b0;
        cand_start  = run_start_q;
        cand_end    = col_q;
        if (frame_start) begin
            run_open_d  = 1'b0;
            run_start_d = '0;
        end else if (accept) begin
            if (object_image) begin
                if (!run_open_q) begin
                    run_open_d  = 1'b1;
                    run_start_d = col_q;
                    cand_start  = col_q;
                end
                if (end_of_row) begin
                    cand_valid = 1'b1;
                    cand_end   = col_q;
                    run_open_d = 1'b0;
                end
            end else if (run_open_q) begin
                cand_valid = 1'b1;
                cand_end   = col_q - 9'd1;
                run_open_d = 1'b0;
            end
        end
        cand_width = cand_end - cand_start + 9'd1;
    end

    // Widest run of the current row; strict compare keeps the leftmost on ties.
    always_comb begin
        row_upd   = cand_valid && (cand_width > row_w_q);
        row_w_new = row_upd ? cand_width : row_w_q;
        row_s_new = row_upd ? cand_start : row_s_q;
        row_e_new = row_upd ? cand_end   : row_e_q;
        row_w_d   = row_w_q;
        row_s_d   = row_s_q;
        row_e_d   = row_e_q;
        if (frame_start || (accept && end_of_row)) begin
            row_w_d = '0;
            row_s_d = '0;
            row_e_d = '0;
        end else if (accept) begin
            row_w_d = row_w_new;
            row_s_d = row_s_new;
            row_e_d = row_e_new;
        end
    end

    // Frame best: eligible rows replace it only when strictly wider, so the earlier row wins ties.
    always_comb begin
        take_row   = accept && end_of_row && (row_q >= ROW_MIN) && (row_w_new > best_w_q);
        best_w_d   = best_w_q;
        best_s_d   = best_s_q;
        best_e_d   = best_e_q;
        best_row_d = best_row_q;
        if (frame_start) begin
            best_w_d   = '0;
            best_s_d   = '0;
            best_e_d   = '0;
            best_row_d = '0;
        end else if (take_row) begin
            best_w_d   = row_w_new;
            best_s_d   = row_s_new;
            best_e_d   = row_e_new;
            best_row_d = row_q;
        end
    end

    // Published results: cleared on restart, loaded once on the way into DONE, otherwise held.
    always_comb begin
        flag_d       = flag_q;
        palm_width_d = palm_width_q;
        start_d      = start_q;
        end_d        = end_q;
        finger_d     = finger_q;
        palm_row_d   = palm_row_q;
        if (frame_start) begin
            flag_d       = 1'b0;
            palm_width_d = '0;
            start_d      = '0;
            end_d        = '0;
            finger_d     = '0;
            palm_row_d   = '0;
        end else if (state_q == LOAD) begin
            flag_d = 1'b1;
            if (best_w_q >= MIN_W) begin
                palm_width_d = best_w_q;
                start_d      = best_s_q;
                end_d        = best_e_q;
                finger_d     = best_w_q >> 2;
                palm_row_d   = best_row_q;
            end else begin
                palm_width_d = '0;
                start_d      = '0;
                end_d        = '0;
                finger_d     = '0;
                palm_row_d   = '0;
            end
        end
    end

    // State and datapath registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            run_open_q   <= 1'b0;
            run_start_q  <= '0;
            row_w_q      <= '0;
            row_s_q      <= '0;
            row_e_q      <= '0;
            best_w_q     <= '0;
            best_s_q     <= '0;
            best_e_q     <= '0;
            best_row_q   <= '0;
            flag_q       <= 1'b0;
            palm_width_q <= '0;
            start_q      <= '0;
            end_q        <= '0;
            finger_q     <= '0;
            palm_row_q   <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            run_open_q   <= run_open_d;
            run_start_q  <= run_start_d;
            row_w_q      <= row_w_d;
            row_s_q      <= row_s_d;
            row_e_q      <= row_e_d;
            best_w_q     <= best_w_d;
            best_s_q     <= best_s_d;
            best_e_q     <= best_e_d;
            best_row_q   <= best_row_d;
            flag_q       <= flag_d;
            palm_width_q <= palm_width_d;
            start_q      <= start_d;
            end_q        <= end_d;
            finger_q     <= finger_d;
            palm_row_q   <= palm_row_d;
        end
    end

    assign flag            = flag_q;
    assign palm_width      = palm_width_q;
    assign start_of_palm_c = start_q;
    assign end_of_palm_c   = end_q;
    assign finger_width    = finger_q;
    assign palm_row        = palm_row_q;

endmodule
